regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Sequencer and arbiter for the single write port of the parameterised register file (write enable, write address, write data, posedge write).
- After reset, and on request, it sweeps every entry to a fill value.
- Otherwise it grants the write port to one of two requesters in round-robin order, using a valid/ready handshake.
- Sits between producer blocks and the register file; the register file's read port is not touched.

Parameters:
- DATA_WIDTH, 8, width of write data.
- ADDR_WIDTH, 2, register file address width; DEPTH = 2**ADDR_WIDTH entries.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- clear_req  input  1  single-cycle pulse; restarts the fill sweep.
- fill_data  input  DATA_WIDTH  value written to every entry during a sweep.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  ADDR_WIDTH  requester 0 target address.
- req0_data  input  DATA_WIDTH  requester 0 write data.
- req0_ready  output  1  requester 0 write accepted this cycle.
- req1_valid, req1_addr, req1_data, req1_ready  as for requester 0.
- init_done  output  1  high while in RUN.
- rf_w_en  output  1  to register file write enable.
- rf_w_addr  output  ADDR_WIDTH  to register file write address.
- rf_w_data  output  DATA_WIDTH  to register file write data.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is synchronous and active-low: rst_n is sampled only at posedge clk.
- Reset (rst_n low at an edge):
  - state=SWEEP, cnt=0, prio=0.
  - rf_w_en=0, rf_w_addr=0, rf_w_data=0, init_done=0.
  - Reset mid-sweep or mid-RUN aborts everything. A write already registered is dropped (rf_w_en cleared).
- State SWEEP (cnt counts 0..DEPTH-1, ADDR_WIDTH+1 bits or a terminal flag):
  - Each edge registers rf_w_en=1, rf_w_addr=cnt, rf_w_data=fill_data, then cnt++.
  - On the edge that issues addr DEPTH-1: state<=RUN, init_done<=1.
  - Sweep therefore occupies exactly DEPTH edges. req*_ready=0 throughout.
- State RUN, combinational ready:
  - req0_ready = RUN & !clear_req & req0_valid & (!req1_valid | prio==0).
  - req1_ready = RUN & !clear_req & req1_valid & (!req0_valid | prio==1).
  - At most one ready high per cycle. Ready never high without its own valid.
- Handshake:
  - A handshake is valid&ready at an edge.
  - On that edge, register rf_w_en=1 with the granted requester's addr/data.
  - The register file captures the write on the following edge, so write-to-readable latency is 2 edges from handshake.
  - No handshake: rf_w_en<=0; addr/data hold their previous values.
  - Requesters hold valid/addr/data stable until ready. The arbiter never drops or duplicates a request.
- Round-robin:
  - After granting requester k, prio<=1-k.
  - With a single requester active, it is granted every cycle (back-to-back, 1 write/cycle).
  - prio is unchanged when there is no grant.
- clear_req:
  - In RUN: state<=SWEEP, cnt<=0, init_done<=0. No grant that cycle (clear wins over simultaneous requests). rf_w_en<=0 that edge.
  - In SWEEP: restarts at cnt=0 using the current fill_data.
  - Ignored while rst_n is low.
- Addresses wrap naturally within ADDR_WIDTH; there are no out-of-range cases.

Test Plan:
- Reset then release, DEPTH=4, fill_data=8'h00 → rf_w_en high 4 consecutive edges, addrs 0,1,2,3, data 00; init_done rises with the addr-3 write; ready low throughout.
- RUN, only req0 valid, addr 2 data 8'hA5, held 3 cycles with new addr/data each cycle → ready high every cycle; rf_w_* shows three writes on consecutive cycles, order preserved.
- RUN, both valid continuously (req0 addr1/8'h11, req1 addr2/8'h22), prio=0 → grants alternate 0,1,0,1; rf_w_addr sequence 1,2,1,2.
- Both valid with clear_req pulsed, fill_data=8'hFF → no ready that cycle; sweep writes FF to 0..3; requests are granted only after init_done, still pending and unduplicated.
- clear_req pulsed at sweep cnt=2 → sweep restarts at addr 0; exactly DEPTH further writes before init_done.
- rst_n low for one edge mid-RUN with a handshake in flight → next cycle rf_w_en=0, init_done=0, prio=0; full sweep follows.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-request bundle between two producer blocks and the register-file write arbiter.
// Producers drive the master side; the arbiter answers on the slave side.
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: fills every entry after reset or clear_req,
// then grants two requesters in round-robin order through a valid/ready handshake.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_req,
    input  logic [DATA_WIDTH-1:0]  fill_data,
    regfile_write_arbiter_if.slave req,
    output logic                   init_done,
    output logic                   rf_w_en,
    output logic [ADDR_WIDTH-1:0]  rf_w_addr,
    output logic [DATA_WIDTH-1:0]  rf_w_data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                state_r, state_nx_s;
    logic [ADDR_WIDTH:0]   cnt_r, cnt_nx_s;
    logic                  prio_r, prio_nx_s;
    logic                  w_en_r, w_en_nx_s;
    logic [ADDR_WIDTH-1:0] w_addr_r, w_addr_nx_s;
    logic [DATA_WIDTH-1:0] w_data_r, w_data_nx_s;
    logic                  done_r, done_nx_s;
    logic                  ready0_s, ready1_s;

    // Grant decision: clear_req suppresses every grant in the cycle it is seen.
    always_comb begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        if ((state_r == ST_RUN) && !clear_req) begin
            ready0_s = req.req0_valid && (!req.req1_valid || (prio_r == 1'b0));
            ready1_s = req.req1_valid && (!req.req0_valid || (prio_r == 1'b1));
        end else begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end
    end

    // Next-state and next-output logic; address/data hold when nothing is written.
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        prio_nx_s   = prio_r;
        w_en_nx_s   = 1'b0;
        w_addr_nx_s = w_addr_r;
        w_data_nx_s = w_data_r;
        done_nx_s   = done_r;
        case (state_r)
            ST_SWEEP: begin
                if (clear_req) begin
                    cnt_nx_s = {(ADDR_WIDTH+1){1'b0}};
                end else begin
                    w_en_nx_s   = 1'b1;
                    w_addr_nx_s = cnt_r[ADDR_WIDTH-1:0];
                    w_data_nx_s = fill_data;
                    if (cnt_r[ADDR_WIDTH-1:0] == LAST_ADDR) begin
                        state_nx_s = ST_RUN;
                        done_nx_s  = 1'b1;
                        cnt_nx_s   = {(ADDR_WIDTH+1){1'b0}};
                    end else begin
                        cnt_nx_s = cnt_r + (ADDR_WIDTH+1)'(1);
                    end
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_nx_s = ST_SWEEP;
                    cnt_nx_s   = {(ADDR_WIDTH+1){1'b0}};
                    done_nx_s  = 1'b0;
                end else if (ready0_s) begin
                    w_en_nx_s   = 1'b1;
                    w_addr_nx_s = req.req0_addr;
                    w_data_nx_s = req.req0_data;
                    prio_nx_s   = 1'b1;
                end else if (ready1_s) begin
                    w_en_nx_s   = 1'b1;
                    w_addr_nx_s = req.req1_addr;
                    w_data_nx_s = req.req1_data;
                    prio_nx_s   = 1'b0;
                end else begin
                    w_en_nx_s = 1'b0;
                end
            end
            default: begin
                state_nx_s = ST_SWEEP;
                cnt_nx_s   = {(ADDR_WIDTH+1){1'b0}};
                done_nx_s  = 1'b0;
            end
        endcase
    end

    // State and registered write-port outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_SWEEP;
            cnt_r    <= {(ADDR_WIDTH+1){1'b0}};
            prio_r   <= 1'b0;
            w_en_r   <= 1'b0;
            w_addr_r <= {ADDR_WIDTH{1'b0}};
            w_data_r <= {DATA_WIDTH{1'b0}};
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            cnt_r    <= cnt_nx_s;
            prio_r   <= prio_nx_s;
            w_en_r   <= w_en_nx_s;
            w_addr_r <= w_addr_nx_s;
            w_data_r <= w_data_nx_s;
            done_r   <= done_nx_s;
        end
    end

    assign req.req0_ready = ready0_s;
    assign req.req1_ready = ready1_s;
    assign init_done      = done_r;
    assign rf_w_en        = w_en_r;
    assign rf_w_addr      = w_addr_r;
    assign rf_w_data      = w_data_r;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed plus randomized bench for regfile_write_arbiter against a transaction-level
// model of the sweep/round-robin rules and a shadow copy of the register file.
module tb_regfile_write_arbiter;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_req;
    logic [DW-1:0] fill_data;
    logic          init_done;
    logic          rf_w_en;
    logic [AW-1:0] rf_w_addr;
    logic [DW-1:0] rf_w_data;

    regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .fill_data (fill_data),
        .req       (bus.slave),
        .init_done (init_done),
        .rf_w_en   (rf_w_en),
        .rf_w_addr (rf_w_addr),
        .rf_w_data (rf_w_data)
    );

    always #5 clk = ~clk;

    // The register file this arbiter feeds.
    logic [DW-1:0] rf_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (rf_w_en) rf_mem[rf_w_addr] <= rf_w_data;
    end

    int checks   = 0;
    int failures = 0;

    // Stimulus state: pending request per requester, held until granted.
    bit            pv [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    bit            clr  = 1'b0;
    bit            rstn = 1'b0;
    logic [DW-1:0] fill = 8'h00;

    // Reference model: sweep progress as an index, round-robin as "whose turn".
    bit            m_known = 1'b0;
    bit            m_run   = 1'b0;
    int            m_idx   = 0;
    int            m_turn  = 0;
    bit            m_en    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;
    logic [DW-1:0] m_mem [DEPTH];
    bit            g0, g1;
    int            addr_log [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit r0, r1;
        bus.req0_valid = pv[0]; bus.req0_addr = pa[0]; bus.req0_data = pd[0];
        bus.req1_valid = pv[1]; bus.req1_addr = pa[1]; bus.req1_data = pd[1];
        clear_req = clr; fill_data = fill; rst_n = rstn;
        #2;
        r0 = m_run && !clr && pv[0] && (!pv[1] || m_turn == 0);
        r1 = m_run && !clr && pv[1] && (!pv[0] || m_turn == 1);
        if (m_known) begin
            check("req0_ready", {31'd0, bus.req0_ready}, {31'd0, r0});
            check("req1_ready", {31'd0, bus.req1_ready}, {31'd0, r1});
        end
        if (m_en) m_mem[m_addr] = m_data;
        g0 = 1'b0; g1 = 1'b0;
        if (!rstn) begin
            m_run = 1'b0; m_idx = 0; m_turn = 0;
            m_en = 1'b0; m_addr = '0; m_data = '0;
        end else if (!m_run) begin
            if (clr) begin
                m_idx = 0; m_en = 1'b0;
            end else begin
                m_en = 1'b1; m_addr = AW'(m_idx); m_data = fill;
                m_idx++;
                if (m_idx == DEPTH) begin m_run = 1'b1; m_idx = 0; end
            end
        end else if (clr) begin
            m_run = 1'b0; m_idx = 0; m_en = 1'b0;
        end else if (r0 || r1) begin
            g0 = r0; g1 = r1;
            m_en   = 1'b1;
            m_addr = r0 ? pa[0] : pa[1];
            m_data = r0 ? pd[0] : pd[1];
            m_turn = r0 ? 1 : 0;
        end else begin
            m_en = 1'b0;
        end
        @(posedge clk);
        #1;
        m_known = 1'b1;
        check("rf_w_en",   {31'd0, rf_w_en},   {31'd0, m_en});
        check("rf_w_addr", {30'd0, rf_w_addr}, {30'd0, m_addr});
        check("rf_w_data", {24'd0, rf_w_data}, {24'd0, m_data});
        check("init_done", {31'd0, init_done}, {31'd0, m_run});
        addr_log.push_back(int'(rf_w_addr));
        if (g0) pv[0] = 1'b0;
        if (g1) pv[1] = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        pv[0] = 1'b0; pv[1] = 1'b0;
        pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;

        // Reset, then first fill sweep with zero data.
        rstn = 1'b0; step(); step();
        rstn = 1'b1; fill = 8'h00;
        for (int i = 0; i < DEPTH; i++) step();

        // Single requester streams back-to-back with fresh addr/data each cycle.
        pv[0] = 1'b1; pa[0] = 2'd2; pd[0] = 8'hA5; step();
        pv[0] = 1'b1; pa[0] = 2'd3; pd[0] = 8'h5A; step();
        pv[0] = 1'b1; pa[0] = 2'd0; pd[0] = 8'h3C; step();

        // Hand the turn back to requester 0, then both contend.
        pv[1] = 1'b1; pa[1] = 2'd1; pd[1] = 8'h77; step();
        addr_log.delete();
        for (int i = 0; i < 4; i++) begin
            pv[0] = 1'b1; pa[0] = 2'd1; pd[0] = 8'h11;
            pv[1] = 1'b1; pa[1] = 2'd2; pd[1] = 8'h22;
            step();
        end
        check("rr_seq0", addr_log[0], 1);
        check("rr_seq1", addr_log[1], 2);
        check("rr_seq2", addr_log[2], 1);
        check("rr_seq3", addr_log[3], 2);

        // clear_req wins over pending requests; they survive the sweep.
        pv[0] = 1'b1; pa[0] = 2'd3; pd[0] = 8'hC3;
        pv[1] = 1'b1; pa[1] = 2'd0; pd[1] = 8'h3C;
        fill = 8'hFF; clr = 1'b1; step();
        for (int i = 0; i < DEPTH + 2; i++) step();
        check("pending_drained", {30'd0, pv[1], pv[0]}, 32'd0);

        // clear_req mid-sweep restarts from address 0.
        clr = 1'b1; fill = 8'h42; step();
        step(); step();
        clr = 1'b1; fill = 8'h99; step();
        for (int i = 0; i < DEPTH; i++) step();

        // Reset with a handshake in flight, then a full sweep and fresh priority.
        pv[1] = 1'b1; pa[1] = 2'd2; pd[1] = 8'hE1; step();
        rstn = 1'b0; step();
        rstn = 1'b1; fill = 8'h5C;
        for (int i = 0; i < DEPTH; i++) step();
        pv[0] = 1'b1; pa[0] = 2'd1; pd[0] = 8'hD0;
        pv[1] = 1'b1; pa[1] = 2'd3; pd[1] = 8'hD1;
        step(); step();

        // Randomized traffic with occasional clear and reset.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pv[k] && $urandom_range(0, 2) != 0) begin
                    pv[k] = 1'b1;
                    pa[k] = AW'($urandom);
                    pd[k] = DW'($urandom);
                end
            end
            clr  = ($urandom_range(0, 39) == 0);
            rstn = ($urandom_range(0, 149) != 0);
            fill = DW'($urandom);
            step();
            rstn = 1'b1;
        end

        // Let the last write land, then compare register file contents.
        pv[0] = 1'b0; pv[1] = 1'b0;
        step(); step();
        for (int i = 0; i < DEPTH; i++) check("rf_contents", {24'd0, rf_mem[i]}, {24'd0, m_mem[i]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
